// File: rtl/prbs31_test_ctrl.sv
// prbs31_test_ctrl
//   Sequencer and loopback checker for a PRBS31 generator (x^31 + x^28 + 1,
//   shift-left, new bit = b[27]^b[30]). A start request seeds the generator,
//   runs it for burst_len bits (or until stop when burst_len is 0) and checks
//   the looped-back stream with a self-synchronising checker.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a test (IDLE only)
//   stop            end a test early (LOAD/RUN)
//   burst_len       bits to generate, 0 = continuous
//   seed            generator seed, 0 is replaced by 1
//   rx_bit          looped-back serial bit, sampled every RUN cycle
//   gen_load        one-cycle seed load strobe, gen_seed valid with it
//   gen_en          generator advance enable
//   busy / done     test in progress / one-cycle completion pulse
//   locked          checker synchronised (sticky until next start)
//   err_cnt         mismatches since lock, saturating
//   bit_cnt         RUN cycles elapsed, wraps in continuous mode
module prbs31_test_ctrl #(
  parameter int BURST_W = 16,
  parameter int ERR_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [30:0]        seed,
  input  logic               rx_bit,
  output logic               gen_load,
  output logic [30:0]        gen_seed,
  output logic               gen_en,
  output logic               busy,
  output logic               done,
  output logic               locked,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [BURST_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_gen_load;
  logic [30:0]        r_gen_seed;
  logic               r_gen_en;
  logic               r_busy;
  logic               r_done;
  logic               r_locked;
  logic [ERR_W-1:0]   r_err;
  logic [BURST_W-1:0] r_bit_cnt;
  logic [30:0]        r_chk;
  logic [4:0]         r_fill;   // samples shifted in, stops at 31
  logic [4:0]         r_match;  // consecutive matches while hunting for lock

  logic               w_start_acc;
  logic               w_run;
  logic               w_last;
  logic               w_mis;
  logic [BURST_W-1:0] w_len_m1;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_run       = (r_state == S_RUN);
  assign w_len_m1    = burst_len - {{(BURST_W-1){1'b0}}, 1'b1};
  // bit_cnt still holds the pre-increment count, so N-1 marks the Nth bit
  assign w_last      = (burst_len != '0) && (r_bit_cnt == w_len_m1);
  assign w_mis       = (r_chk[27] ^ r_chk[30]) ^ rx_bit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = stop ? S_DONE : S_RUN;
      S_RUN:  if (stop || w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered and
  // aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gen_load <= 1'b0;
      r_gen_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gen_seed <= 31'd1;
    end else begin
      r_state    <= w_next;
      r_gen_load <= (w_next == S_LOAD);
      r_gen_en   <= (w_next == S_RUN);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);
      if (w_start_acc) r_gen_seed <= (seed == 31'd0) ? 31'd1 : seed;
    end
  end

  // Checker: fill 31 samples, then require 31 consecutive matches to lock.
  // Once locked, every mismatch counts; a single flipped bit therefore shows
  // up three times (directly, then as tap 27 and tap 30).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk     <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_locked  <= 1'b0;
      r_err     <= '0;
      r_bit_cnt <= '0;
    end else if (w_start_acc) begin
      r_chk     <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_locked  <= 1'b0;
      r_err     <= '0;
      r_bit_cnt <= '0;
    end else if (w_run) begin
      r_bit_cnt <= r_bit_cnt + {{(BURST_W-1){1'b0}}, 1'b1};
      r_chk     <= {r_chk[29:0], rx_bit};
      if (r_fill != 5'd31) begin
        r_fill <= r_fill + 5'd1;
      end else if (!r_locked) begin
        if (w_mis)                  r_match  <= '0;
        else if (r_match == 5'd30)  r_locked <= 1'b1;
        else                        r_match  <= r_match + 5'd1;
      end else if (w_mis && (r_err != '1)) begin
        r_err <= r_err + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign gen_load = r_gen_load;
  assign gen_seed = r_gen_seed;
  assign gen_en   = r_gen_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign locked   = r_locked;
  assign err_cnt  = r_err;
  assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_prbs31_test_ctrl.sv
// Bench for prbs31_test_ctrl: a behavioural PRBS31 generator closes the loop,
// stimulus pushes the expected result of each test into a queue, and a
// monitor pops and compares whenever the DUT pulses done.
module tb_prbs31_test_ctrl;
  localparam int BW = 16;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [30:0]   seed = '0;
  logic          rx_bit;
  logic          gen_load;
  logic [30:0]   gen_seed;
  logic          gen_en;
  logic          busy;
  logic          done;
  logic          locked;
  logic [EW-1:0] err_cnt;
  logic [BW-1:0] bit_cnt;

  always #5 clk = ~clk;

  prbs31_test_ctrl #(.BURST_W(BW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .burst_len(burst_len), .seed(seed), .rx_bit(rx_bit),
    .gen_load(gen_load), .gen_seed(gen_seed), .gen_en(gen_en),
    .busy(busy), .done(done), .locked(locked), .err_cnt(err_cnt),
    .bit_cnt(bit_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Generator model and loopback path
  logic [30:0] lfsr = 31'd1;
  logic [7:0]  dly = '0;
  int          lat = 0;       // loopback latency in samples
  int          mode = 0;      // 0 gen, 1 stuck-1, 2 stuck-0, 3 invert from sample 100
  int          samp = 0;      // index of the current RUN sample
  int          flip_idx = -1;
  logic        src;

  always @(posedge clk) begin
    if (gen_load) begin
      lfsr <= gen_seed;
      dly  <= '0;
      samp <= 0;
    end else if (gen_en) begin
      lfsr <= {lfsr[29:0], lfsr[27] ^ lfsr[30]};
      dly  <= {dly[6:0], lfsr[30]};
      samp <= samp + 1;
    end
  end

  always_comb begin
    src = (lat == 0) ? lfsr[30] : dly[lat-1];
    case (mode)
      1:       rx_bit = 1'b1;
      2:       rx_bit = 1'b0;
      3:       rx_bit = (samp >= 100) ? ~src : src;
      default: rx_bit = src ^ (samp == flip_idx);
    endcase
  end

  // Scoreboard
  typedef struct {
    logic [30:0] seed;
    int          en;
    int          bits;
    logic        lck;
    int          err;
  } exp_t;
  exp_t q[$];

  int          cyc = 0;
  int          load_cyc = 0;
  int          en_cnt = 0;
  logic [30:0] cap_seed = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (gen_load) begin
          load_cyc = cyc;
          en_cnt   = 0;
          cap_seed = gen_seed;
        end
        if (gen_en) en_cnt++;
        if (done) begin
          if (q.size() == 0) begin
            check("spurious_done_queue", q.size(), 1);
          end else begin
            e = q.pop_front();
            check("gen_seed_at_load", cap_seed, e.seed);
            check("gen_en_cycles", en_cnt, e.en);
            check("done_latency", cyc - load_cyc, e.en + 1);
            check("bit_cnt", bit_cnt, e.bits);
            check("locked", locked, e.lck);
            check("err_cnt", err_cnt, e.err);
          end
        end
      end
    end
  end

  // Stimulus helpers; all are entered and left on a negedge
  task automatic push_exp(input logic [30:0] es, input int en, input int bits,
                          input logic el, input int ee);
    exp_t e;
    e.seed = es; e.en = en; e.bits = bits; e.lck = el; e.err = ee;
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [30:0] sd, input int n);
    seed = sd;
    burst_len = BW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("busy_low_after_done", busy, 0);
  endtask

  task automatic run_burst(input logic [30:0] sd, input int n, input int l, input int m,
                           input int fi, input logic [30:0] es, input logic el, input int ee);
    lat = l; mode = m; flip_idx = fi;
    push_exp(es, n, n, el, ee);
    pulse_start(sd, n);
    wait_done(n + 20);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gen_load", gen_load, 0);
    check("rst_gen_en", gen_en, 0);
    check("rst_gen_seed", gen_seed, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_locked", locked, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-run: outputs drop without a clock edge
    lat = 0; mode = 0; flip_idx = -1;
    pulse_start(31'h55, 1000);
    repeat (20) @(negedge clk);
    check("pre_rst_gen_en", gen_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_gen_en", gen_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_gen_seed", gen_seed, 1);
    check("async_rst_bit_cnt", bit_cnt, 0);
    @(negedge clk);
    check("async_rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean bursts, latency 0 and 5 (back-to-back starts follow each done)
    run_burst(31'd1, 100, 0, 0, -1, 31'd1, 1'b1, 0);
    run_burst(31'd1, 100, 5, 0, -1, 31'd1, 1'b1, 0);
    // Single flipped sample #80 -> three errors
    run_burst(31'h1234_5678, 200, 0, 0, 79, 31'h1234_5678, 1'b1, 3);
    // Stuck inputs
    run_burst(31'd5, 200, 0, 1, -1, 31'd5, 1'b0, 0);
    run_burst(31'd5, 200, 0, 2, -1, 31'd5, 1'b1, 0);

    // Seed 0 is replaced by 1; a start while busy is ignored
    lat = 0; mode = 2; flip_idx = -1;
    push_exp(31'd1, 10, 10, 1'b0, 0);
    pulse_start(31'd0, 10);
    repeat (2) @(negedge clk);
    seed = 31'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    check("seed_after_ignored_start", gen_seed, 1);

    // Stop in LOAD: zero RUN cycles, done next cycle
    push_exp(31'd9, 0, 0, 1'b0, 0);
    pulse_start(31'd9, 50);
    check("in_load_gen_load", gen_load, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(5);

    // Continuous run of 70000 bits, stop on the last; bit_cnt wraps to 4464
    lat = 0; mode = 0; flip_idx = -1;
    push_exp(31'd1, 70000, 4464, 1'b1, 0);
    pulse_start(31'd1, 0);
    @(negedge clk);
    repeat (70000 - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(5);

    // Inverted stream after lock: 4-bit error counter saturates at 15
    run_burst(31'd1, 200, 0, 3, -1, 31'd1, 1'b1, 15);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
